// File: rtl/scrambler_par.sv
// scrambler_par: 802.11a x^7+x^4+1 scrambler/descrambler, DATA_W bits per beat.
// Scramble mode loads the LFSR from seed; descramble mode rebuilds the
// transmitter's LFSR state from the first SYNC_BITS received bits.
//
// Handshakes: a beat moves on an interface in the cycle where valid && ready
// are both high at the rising edge; valid never waits on ready, and data/last
// are held stable while valid is high and ready is low.
module scrambler_par #(
   parameter int DATA_W    = 8,
   parameter int SYNC_BITS = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic [6:0]        seed,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_tail,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              seed_err,
   output logic [1:0]        dbg_state
);

   localparam int CNT_W = $clog2(SYNC_BITS + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SYNC = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]        r_state;
   logic [6:0]        r_lfsr;
   logic [CNT_W-1:0]  r_sync_cnt;
   logic              r_mode;
   logic              r_seed_err;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;

   logic              w_accept;
   logic [6:0]        w_lfsr_nx;
   logic [CNT_W-1:0]  w_cnt_nx;
   logic              w_sync_nx;
   logic              w_fb;
   logic [DATA_W-1:0] w_y;

   assign in_ready  = (r_state != S_IDLE) && !start && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign seed_err  = r_seed_err;
   assign dbg_state = r_state;

   // Walk the beat bit by bit (bit 0 first), switching from SYNC to RUN rules mid-beat if needed.
   always_comb begin
      w_lfsr_nx = r_lfsr;
      w_cnt_nx  = r_sync_cnt;
      w_sync_nx = (r_state == S_SYNC);
      w_fb      = 1'b0;
      w_y       = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_fb = w_lfsr_nx[6] ^ w_lfsr_nx[3];
         if (w_sync_nx) begin
            // SERVICE bits are scrambled zeros, so each received bit is the feedback bit.
            w_y[i]    = 1'b0;
            w_lfsr_nx = {w_lfsr_nx[5:0], in_data[i]};
            w_cnt_nx  = w_cnt_nx + CNT_W'(1);
            if (w_cnt_nx == CNT_W'(SYNC_BITS)) begin
               w_sync_nx = 1'b0;
            end
         end else begin
            w_y[i]    = in_data[i] ^ w_fb;
            w_lfsr_nx = {w_lfsr_nx[5:0], w_fb};
         end
         // Tail bits are forced low after scrambling; the LFSR keeps running.
         if (r_mode && in_tail[i]) begin
            w_y[i] = 1'b0;
         end
      end
   end

   // Frame control: start (re)opens a frame, accepted beats advance the LFSR and state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_lfsr     <= '0;
         r_sync_cnt <= '0;
         r_mode     <= 1'b0;
         r_seed_err <= 1'b0;
      end else if (start) begin
         r_mode     <= mode;
         r_seed_err <= mode && (seed == 7'd0);
         r_sync_cnt <= '0;
         if (mode) begin
            r_lfsr  <= seed;
            r_state <= S_RUN;
         end else begin
            r_state <= S_SYNC;
         end
      end else if (w_accept) begin
         r_lfsr     <= w_lfsr_nx;
         r_sync_cnt <= w_cnt_nx;
         if (in_last) begin
            r_state <= S_IDLE;
         end else if (w_sync_nx) begin
            r_state <= S_SYNC;
         end else begin
            r_state <= S_RUN;
         end
      end
   end

   // Output register: load on acceptance, release once downstream takes the beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_y;
         r_out_last  <= in_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scrambler_par.sv
// tb_scrambler_par: randomized scoreboard bench for scrambler_par (DATA_W = 8).
// The reference model builds the scrambling sequence from the recurrence
// s[n] = s[n-7] ^ s[n-4], seeded with s[-7..-1] = seed[6..0].
module tb_scrambler_par;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         mode;
   logic [6:0]   seed;
   logic         start;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [W-1:0] in_tail;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         seed_err;
   logic [1:0]   dbg_state;

   scrambler_par #(.DATA_W(W), .SYNC_BITS(7)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .seed      (seed),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tail   (in_tail),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .seed_err  (seed_err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int           n_checks = 0;
   int           n_pass   = 0;
   logic [W:0]   exp_q[$];           // {last, data}
   logic [W-1:0] cap_q[$];
   bit           cap_en  = 1'b0;
   int           bp_mode = 0;        // 0: always ready, 1: random, 2: stalled

   // ---------------- reference model ----------------
   bit           h_bits[0:4102];
   bit           seq_bits[0:4095];
   int           pos;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endtask

   task automatic model_start(input logic [6:0] s);
      pos = 0;
      for (int k = 0; k < 7; k++) h_bits[k] = s[6-k];
      for (int k = 7; k < 4103; k++) begin
         h_bits[k]     = h_bits[k-7] ^ h_bits[k-4];
         seq_bits[k-7] = h_bits[k];
      end
   endtask

   task automatic model_scr(input logic [W-1:0] d, input logic [W-1:0] t, output logic [W-1:0] y);
      for (int i = 0; i < W; i++) begin
         y[i] = t[i] ? 1'b0 : (d[i] ^ seq_bits[pos]);
         pos++;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [W-1:0] d, input logic [W-1:0] t, input logic l,
                            input logic [W-1:0] e);
      bit acc;
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_tail  = t;
      in_last  = l;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            exp_q.push_back({l, e});
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic scr_beat(input logic [W-1:0] d, input logic [W-1:0] t, input logic l);
      logic [W-1:0] y;
      model_scr(d, t, y);
      send_beat(d, t, l, y);
   endtask

   task automatic go_idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_tail  = '0;
   endtask

   task automatic do_start(input logic m, input logic [6:0] s);
      start = 1'b1;
      mode  = m;
      seed  = s;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (m) model_start(s);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 2000) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("drain_left", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- out_ready driver ----------------
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // ---------------- monitor ----------------
   logic [W:0]   mon_e;
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_data;
   logic         prev_last;

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, prev_last, prev_data});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("out_beat", {23'd0, out_last, out_data}, {23'd0, mon_e});
            end
            if (cap_en) cap_q.push_back(out_data);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   logic [W-1:0] gold[4];
   logic [W-1:0] plain[40];
   logic [W-1:0] scr[40];
   logic [W-1:0] e;
   logic [W-1:0] d;
   int           hits;

   initial begin
      reset    = 1'b0;
      mode     = 1'b0;
      seed     = '0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_tail  = '0;
      in_last  = 1'b0;
      gold     = '{8'h70, 8'h4F, 8'h93, 8'h40};

      // Reset values
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_seed_err", seed_err, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_state", dbg_state, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Golden sequence: seed 7F, sixteen zero beats
      cap_en = 1'b1;
      do_start(1'b1, 7'h7F);
      chk("golden_seed_err", seed_err, 0);
      chk("golden_state_run", dbg_state, 2);
      for (int b = 0; b < 16; b++) scr_beat('0, '0, b == 15);
      go_idle();
      drain();
      cap_en = 1'b0;
      chk("golden_count", cap_q.size(), 16);
      if (cap_q.size() == 16) begin
         for (int b = 0; b < 4; b++) chk("golden_byte", cap_q[b], gold[b]);
         chk("golden_period", cap_q[15][7], cap_q[0][0]);
      end

      // Beats offered in IDLE must not be taken
      in_valid = 1'b1;
      hits = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (in_ready) hits++;
      end
      chk("idle_no_accept", hits, 0);
      @(posedge clk);
      #1;
      go_idle();

      // Loopback, without and then with random backpressure
      for (int b = 0; b < 40; b++) plain[b] = (b < 2) ? 8'h00 : 8'($urandom);
      for (int run = 0; run < 2; run++) begin
         bp_mode = run;
         do_start(1'b1, 7'h5D);
         for (int b = 0; b < 40; b++) begin
            model_scr(plain[b], '0, e);
            scr[b] = e;
            send_beat(plain[b], '0, b == 39, e);
         end
         go_idle();
         drain();
         do_start(1'b0, 7'($urandom));
         chk("desc_state_sync", dbg_state, 1);
         for (int b = 0; b < 40; b++) begin
            e = plain[b];
            if (b == 0) e[6:0] = 7'd0;
            send_beat(scr[b], 8'($urandom), b == 39, e);
         end
         go_idle();
         drain();
      end
      bp_mode = 0;

      // Tail zeroing, then the same seed replays the same sequence
      do_start(1'b1, 7'h33);
      for (int b = 0; b < 4; b++) scr_beat(8'($urandom), (b == 3) ? 8'h3F : 8'h00, b == 3);
      go_idle();
      drain();
      do_start(1'b1, 7'h33);
      for (int b = 0; b < 4; b++) scr_beat(8'hA5, '0, b == 3);
      go_idle();
      drain();

      // Start together with a valid beat aborts the frame; beat waits for the new seed
      do_start(1'b1, 7'h5D);
      for (int b = 0; b < 3; b++) scr_beat(8'($urandom), '0, 1'b0);
      d        = 8'($urandom);
      in_valid = 1'b1;
      in_data  = d;
      in_tail  = '0;
      in_last  = 1'b0;
      start    = 1'b1;
      mode     = 1'b1;
      seed     = 7'h2A;
      #1;
      chk("abort_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      model_start(7'h2A);
      scr_beat(d, '0, 1'b0);
      scr_beat(8'($urandom), '0, 1'b1);
      go_idle();
      drain();

      // Zero seed: flagged, data passes unchanged
      do_start(1'b1, 7'h00);
      chk("seed_err_set", seed_err, 1);
      for (int b = 0; b < 3; b++) begin
         d = 8'($urandom);
         send_beat(d, '0, b == 2, d);
      end
      go_idle();
      drain();

      // Reset with a stalled output beat pending
      bp_mode = 2;
      do_start(1'b1, 7'h00);
      send_beat(8'h5A, '0, 1'b0, 8'h5A);
      @(negedge clk);
      chk("pending_before_reset", out_valid, 1);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_seed_err", seed_err, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_state", dbg_state, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset   = 1'b1;
      bp_mode = 0;
      hits    = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (in_ready) hits++;
      end
      chk("ready_low_until_start", hits, 0);
      @(posedge clk);
      #1;
      go_idle();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/scrambler_par.md
Name: scrambler_par

Overview:
- Parametrised 802.11a scrambler/descrambler using the x^7+x^4+1 polynomial, processing DATA_W bits per beat under valid/ready handshakes. Frames are explicit: they open with start and close with last.
- On the TX side it scrambles the DATA field and optionally forces tail bits to zero after scrambling.
- On the RX side it recovers the transmitter's LFSR seed from the first 7 SERVICE bits, so no seed is needed.
- Sits between the PPDU bit framer and the convolutional encoder (TX), and between the Viterbi decoder and the deframer (RX).

Parameters:
- DATA_W, 8, bits per beat (1..16). in_data[0] is the earliest bit in time.
- SYNC_BITS, 7, number of leading bits used for seed recovery in descramble mode. Fixed at 7 for 802.11a.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- mode  input  1  1 = scramble, 0 = descramble. Sampled only on start.
- seed  input  7  initial LFSR state. seed[6] = x7, seed[0] = x1. Sampled on start, used only when mode = 1.
- start  input  1  single-cycle pulse that opens a frame and aborts any frame in progress
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept an input beat
- in_data  input  DATA_W  input bits
- in_tail  input  DATA_W  per-bit mask. A 1 forces that output bit to 0 after scrambling (scramble mode only).
- in_last  input  1  final beat of the frame
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream can accept the output beat
- out_data  output  DATA_W  processed bits
- out_last  output  1  final output beat of the frame
- seed_err  output  1  start was issued with mode = 1 and seed = 0. Level signal; cleared by the next start.

Behaviour:
- Reset (asynchronous, reset = 0):
  - state = IDLE, lfsr = 0, sync_cnt = 0.
  - out_valid = 0, out_data = 0, out_last = 0, seed_err = 0, in_ready = 0.
- States:
  - IDLE: no frame open.
  - SYNC: descramble mode, seed recovery in progress.
  - RUN: normal processing.
- Transitions:
  - start, mode = 1: lfsr <= seed, go to RUN.
  - start, mode = 0: sync_cnt <= 0, go to SYNC.
  - SYNC -> RUN: as soon as sync_cnt reaches 7 (mid-beat allowed; the remaining bits of that beat use RUN rules).
  - RUN or SYNC -> IDLE: when a beat with in_last = 1 is accepted.
  - start while in SYNC or RUN aborts the frame. A pending output beat stays valid and still drains.
- in_ready = (state != IDLE) && !start && (!out_valid || out_ready).
  - A beat is accepted when in_valid && in_ready.
  - Beats presented in IDLE are not accepted.
  - When start and in_valid occur in the same cycle, start wins and the beat waits.
- Per-bit processing, applied sequentially from bit 0 to bit DATA_W-1 within one cycle:
  - fb = lfsr[6] ^ lfsr[3].
  - RUN: y = x ^ fb; lfsr <= {lfsr[5:0], fb}.
  - SYNC: y = 0; lfsr <= {lfsr[5:0], x}; sync_cnt++.
    - Rationale: the SERVICE bits are scrambled zeros, so received bit = fb.
  - Scramble mode only: if in_tail[i] = 1, then y = 0. The lfsr still advances.
- Latency and output register:
  - One cycle: out_data/out_last are registered on acceptance and out_valid is set.
  - out_valid clears when out_ready = 1 and no new beat is accepted in that cycle.
  - Full throughput of one beat per cycle while out_ready = 1.
  - Output holds stable while out_valid && !out_ready.
- seed_err does not block the frame. With an all-zero lfsr, output = input.
- Period: the LFSR sequence repeats every 127 bits. No internal counter limits frame length.
- Reset mid-frame: all state is cleared immediately and any pending output beat is discarded.

Test Plan:
- Golden sequence: DATA_W = 8, mode = 1, seed = 7'h7F, start, then 16 zero beats. Required: out_data = 8'h70, 8'h4F, 8'h93, 8'h40, ... Bits 0..126 must match the 802.11a 127-bit sequence, and bit 127 must equal bit 0.
- Loopback: scramble a 40-byte random frame (zero SERVICE bits first) with seed 7'h5D, then feed the result to a second instance with mode = 0 and arbitrary seed. Required: the first 7 output bits are 0, all following bits equal the original, and out_last is on the final beat.
- Backpressure: toggle out_ready randomly with probability 0.5 and in_valid continuously. Required: no lost or duplicated beats, out_data stable while stalled, and output identical to the no-stall run.
- Tail zeroing: scramble mode, final beat with in_tail = 8'h3F. Required: out_data[5:0] = 0, bits 7:6 scrambled normally, and the next frame started with the same seed reproduces the same sequence.
- Start and abort: start mid-frame together with in_valid. Required: that beat is not accepted (in_ready = 0), the lfsr is reloaded, and the next accepted beat uses the new seed.
- Error and reset: start with mode = 1 and seed = 0. Required: seed_err = 1 and out = in. Then assert reset mid-beat. Required: out_valid = 0 and seed_err = 0 immediately, with in_ready = 0 until the next start.
